// File: rtl/operand_fetch_stage.sv
// ID->EX operand stage: drives regfile reads, forwards EX/MEM and WB results,
// stalls on unresolved RAW hazards and captures operands into the ID/EX register.
module operand_fetch_stage #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 5,
  parameter int unsigned ZR = 31,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rn,
  input  logic [AW-1:0] in_rm,
  input  logic [AW-1:0] in_rd,
  input  logic          in_rn_used,
  input  logic          in_rm_used,
  input  logic          in_regwrite,
  input  logic          in_memread,
  output logic [AW-1:0] ReadRegister1,
  output logic [AW-1:0] ReadRegister2,
  input  logic [DW-1:0] ReadData1,
  input  logic [DW-1:0] ReadData2,
  input  logic          exm_valid,
  input  logic          exm_regwrite,
  input  logic          exm_memread,
  input  logic [AW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          wb_regwrite,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_op1,
  output logic [DW-1:0] out_op2,
  output logic [AW-1:0] out_rd,
  output logic          out_regwrite,
  output logic          out_memread,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [AW-1:0] ZrIdx  = AW'(ZR);
  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  logic          rn_live, rm_live;
  logic          ex_producer, mem_load, exm_alu;
  logic          hazard_ex, hazard_mem, stall, advance;
  logic [DW-1:0] op1_sel, op2_sel;

  assign ReadRegister1 = in_rn;
  assign ReadRegister2 = in_rm;

  // A source only participates in hazards and forwarding when it is read and is not XZR.
  assign rn_live = in_rn_used & (in_rn != ZrIdx);
  assign rm_live = in_rm_used & (in_rm != ZrIdx);

  assign ex_producer = out_valid & out_regwrite & (out_rd != ZrIdx);
  assign mem_load    = exm_valid & exm_regwrite & exm_memread & (exm_rd != ZrIdx);
  assign exm_alu     = exm_valid & exm_regwrite & ~exm_memread;

  assign hazard_ex  = ex_producer & ((rn_live & (in_rn == out_rd)) |
                                     (rm_live & (in_rm == out_rd)));
  assign hazard_mem = mem_load & ((rn_live & (in_rn == exm_rd)) |
                                  (rm_live & (in_rm == exm_rd)));

  assign stall    = in_valid & (hazard_ex | hazard_mem);
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance & ~stall & ~flush;

  // Newest producer wins: EX/MEM ALU result, then WB (regfile has no write bypass).
  always_comb begin
    op1_sel = ReadData1;
    if (in_rn == ZrIdx) begin
      op1_sel = '0;
    end else if (rn_live && exm_alu && (exm_rd == in_rn)) begin
      op1_sel = exm_data;
    end else if (rn_live && wb_regwrite && (wb_rd == in_rn)) begin
      op1_sel = wb_data;
    end
  end

  always_comb begin
    op2_sel = ReadData2;
    if (in_rm == ZrIdx) begin
      op2_sel = '0;
    end else if (rm_live && exm_alu && (exm_rd == in_rm)) begin
      op2_sel = exm_data;
    end else if (rm_live && wb_regwrite && (wb_rd == in_rm)) begin
      op2_sel = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_op1      <= '0;
      out_op2      <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      out_memread  <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (stall && !flush && (stall_cnt != CntMax)) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        if (in_valid && !stall) begin
          out_valid    <= 1'b1;
          out_op1      <= op1_sel;
          out_op2      <= op2_sel;
          out_rd       <= in_rd;
          out_regwrite <= in_regwrite;
          out_memread  <= in_memread;
        end else begin
          out_valid    <= 1'b0;
          out_regwrite <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench: directed hazard/forwarding scenarios plus a random instruction
// stream checked against an in-order architectural model with issue-timing hazards.
module tb_operand_fetch_stage;

  localparam int NumInstr = 10000;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [4:0] rd;
  } hist_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, in_rn_used, in_rm_used, in_regwrite, in_memread;
  logic [4:0]  in_rn, in_rm, in_rd, rr1, rr2;
  logic [63:0] rdata1, rdata2;
  logic        exm_valid, exm_regwrite, exm_memread, wb_regwrite;
  logic [4:0]  exm_rd, wb_rd;
  logic [63:0] exm_data, wb_data;
  logic        flush, out_valid, out_ready, out_regwrite, out_memread;
  logic [63:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_out_regwrite, s_out_memread;
  logic [4:0]  s_rr1, s_rr2, s_out_rd;
  logic [63:0] s_out_op1, s_out_op2;
  logic [2:0]  s_stall_cnt;

  // Environment: directed drivers or an automatic EX/MEM/WB pipeline with a regfile
  logic        pipe_auto;
  logic        d_exm_valid, d_exm_regwrite, d_exm_memread, d_wb_regwrite;
  logic [4:0]  d_exm_rd, d_wb_rd;
  logic [63:0] d_exm_data, d_wb_data, d_rd1, d_rd2;
  logic        a_exm_valid, a_exm_regwrite, a_exm_memread, a_wb_regwrite;
  logic [4:0]  a_exm_rd, a_wb_rd;
  logic [63:0] a_exm_data, a_exm_res, a_wb_data, idex_res, cur_res;
  logic [63:0] rf [32];

  int checks = 0;
  int errors = 0;

  assign exm_valid    = pipe_auto ? a_exm_valid    : d_exm_valid;
  assign exm_regwrite = pipe_auto ? a_exm_regwrite : d_exm_regwrite;
  assign exm_memread  = pipe_auto ? a_exm_memread  : d_exm_memread;
  assign exm_rd       = pipe_auto ? a_exm_rd       : d_exm_rd;
  assign exm_data     = pipe_auto ? a_exm_data     : d_exm_data;
  assign wb_regwrite  = pipe_auto ? a_wb_regwrite  : d_wb_regwrite;
  assign wb_rd        = pipe_auto ? a_wb_rd        : d_wb_rd;
  assign wb_data      = pipe_auto ? a_wb_data      : d_wb_data;
  assign rdata1       = pipe_auto ? rf[rr1]        : d_rd1;
  assign rdata2       = pipe_auto ? rf[rr2]        : d_rd2;

  always @(posedge clk) begin
    if (reset || !pipe_auto) begin
      a_exm_valid <= 1'b0; a_exm_regwrite <= 1'b0; a_exm_memread <= 1'b0; a_exm_rd <= '0;
      a_exm_data <= '0; a_exm_res <= '0; idex_res <= '0;
      a_wb_regwrite <= 1'b0; a_wb_rd <= '0; a_wb_data <= '0;
      if (!pipe_auto) for (int i = 0; i < 32; i++) rf[i] <= 64'hC0DE_0000_0000_0000 | 64'(i);
    end else begin
      a_exm_valid    <= out_valid;
      a_exm_regwrite <= out_regwrite;
      a_exm_memread  <= out_memread;
      a_exm_rd       <= out_rd;
      a_exm_res      <= idex_res;
      // A load's EX/MEM data is an address, not the loaded value
      a_exm_data     <= out_memread ? ~idex_res : idex_res;
      idex_res       <= cur_res;
      a_wb_regwrite  <= a_exm_valid & a_exm_regwrite;
      a_wb_rd        <= a_exm_rd;
      a_wb_data      <= a_exm_res;
      if (a_wb_regwrite) rf[a_wb_rd] <= a_wb_data;
    end
  end

  operand_fetch_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_rn_used(in_rn_used),
    .in_rm_used(in_rm_used), .in_regwrite(in_regwrite), .in_memread(in_memread),
    .ReadRegister1(rr1), .ReadRegister2(rr2), .ReadData1(rdata1), .ReadData2(rdata2),
    .exm_valid(exm_valid), .exm_regwrite(exm_regwrite), .exm_memread(exm_memread),
    .exm_rd(exm_rd), .exm_data(exm_data), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance to observe saturation
  operand_fetch_stage #(.CW(3)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_rn_used(in_rn_used),
    .in_rm_used(in_rm_used), .in_regwrite(in_regwrite), .in_memread(in_memread),
    .ReadRegister1(s_rr1), .ReadRegister2(s_rr2), .ReadData1(rdata1), .ReadData2(rdata2),
    .exm_valid(exm_valid), .exm_regwrite(exm_regwrite), .exm_memread(exm_memread),
    .exm_rd(exm_rd), .exm_data(exm_data), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_op1(s_out_op1), .out_op2(s_out_op2), .out_rd(s_out_rd),
    .out_regwrite(s_out_regwrite), .out_memread(s_out_memread), .stall_cnt(s_stall_cnt)
  );

  task automatic set_instr(input logic [4:0] rn, input logic rn_u, input logic [4:0] rm,
                           input logic rm_u, input logic [4:0] rd, input logic rw,
                           input logic mr);
    in_valid = 1'b1; in_rn = rn; in_rn_used = rn_u; in_rm = rm; in_rm_used = rm_u;
    in_rd = rd; in_regwrite = rw; in_memread = mr;
  endtask

  task automatic do_reset();
    pipe_auto = 1'b0; flush = 1'b0; out_ready = 1'b1; cur_res = '0;
    in_valid = 1'b0; in_rn = '0; in_rm = '0; in_rd = '0; in_rn_used = 1'b0;
    in_rm_used = 1'b0; in_regwrite = 1'b0; in_memread = 1'b0;
    d_exm_valid = 1'b0; d_exm_regwrite = 1'b0; d_exm_memread = 1'b0; d_exm_rd = '0;
    d_exm_data = '0; d_wb_regwrite = 1'b0; d_wb_rd = '0; d_wb_data = '0;
    d_rd1 = '0; d_rd2 = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (out_op1 !== 64'd0 || out_op2 !== 64'd0 || out_rd !== 5'd0 || out_regwrite !== 1'b0 || out_memread !== 1'b0) begin
      errors++; $display("FAIL reset_out_fields got op1=%h op2=%h rd=%0d rw=%0b mr=%0b exp all 0", out_op1, out_op2, out_rd, out_regwrite, out_memread);
    end
    reset = 1'b0;
  endtask

  task automatic test_wb_forward();
    do_reset();
    set_instr(5'd5, 1'b1, 5'd31, 1'b1, 5'd1, 1'b1, 1'b0);
    d_rd1 = 64'd0; d_rd2 = 64'hFFFF_FFFF_FFFF_FFFF;
    d_wb_regwrite = 1'b1; d_wb_rd = 5'd5; d_wb_data = 64'h1234;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wb_in_ready got %0b exp 1", in_ready); end
    checks++; if (rr1 !== 5'd5 || rr2 !== 5'd31) begin errors++; $display("FAIL wb_read_regs got %0d,%0d exp 5,31", rr1, rr2); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wb_out_valid got %0b exp 1", out_valid); end
    checks++; if (out_op1 !== 64'h1234) begin errors++; $display("FAIL wb_op1 got %h exp 1234", out_op1); end
    checks++; if (out_op2 !== 64'd0) begin errors++; $display("FAIL xzr_op2 got %h exp 0", out_op2); end
    checks++; if (out_rd !== 5'd1 || out_regwrite !== 1'b1) begin errors++; $display("FAIL wb_rd got %0d/%0b exp 1/1", out_rd, out_regwrite); end
    in_valid = 1'b0; d_wb_regwrite = 1'b0;
  endtask

  task automatic test_ex_hazard();
    do_reset();
    set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    d_rd1 = 64'h10; d_rd2 = 64'h20;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_op1 !== 64'h10) begin
      errors++; $display("FAIL ex_producer got v=%0b rd=%0d op1=%h exp 1/3/10", out_valid, out_rd, out_op1);
    end
    set_instr(5'd3, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ex_stall_ready got %0b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_regwrite !== 1'b0) begin errors++; $display("FAIL ex_bubble got v=%0b rw=%0b exp 0/0", out_valid, out_regwrite); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL ex_stall_cnt got %0d exp 1", stall_cnt); end
    d_exm_valid = 1'b1; d_exm_regwrite = 1'b1; d_exm_rd = 5'd3; d_exm_data = 64'hAAAA;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ex_resume_ready got %0b exp 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_op1 !== 64'hAAAA || out_op2 !== 64'h20) begin
      errors++; $display("FAIL exm_forward got v=%0b op1=%h op2=%h exp 1/aaaa/20", out_valid, out_op1, out_op2);
    end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL ex_stall_cnt_after got %0d exp 1", stall_cnt); end
    in_valid = 1'b0; d_exm_valid = 1'b0;
  endtask

  task automatic test_load_hazard();
    do_reset();
    d_exm_valid = 1'b1; d_exm_regwrite = 1'b1; d_exm_memread = 1'b1; d_exm_rd = 5'd7;
    d_exm_data = 64'hBAD; d_rd1 = 64'h5; d_rd2 = 64'h6;
    set_instr(5'd7, 1'b1, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_stall_ready got %0b exp 0", in_ready); end
    repeat (10) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld_bubble got %0b exp 0", out_valid); end
    checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL ld_stall_cnt got %0d exp 10", stall_cnt); end
    checks++; if (s_stall_cnt !== 3'd7) begin errors++; $display("FAIL stall_cnt_saturate got %0d exp 7", s_stall_cnt); end
    d_exm_valid = 1'b0;
    d_wb_regwrite = 1'b1; d_wb_rd = 5'd7; d_wb_data = 64'h77;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ld_wb_ready got %0b exp 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_op1 !== 64'h77) begin errors++; $display("FAIL ld_wb_forward got v=%0b op1=%h exp 1/77", out_valid, out_op1); end
    d_wb_regwrite = 1'b0; d_exm_valid = 1'b1; d_exm_rd = 5'd31;
    d_rd1 = 64'hFFFF; d_rd2 = 64'hEEEE;
    set_instr(5'd31, 1'b1, 5'd31, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL xzr_no_stall got %0b exp 1", in_ready); end
    @(negedge clk);
    checks++; if (out_op1 !== 64'd0 || out_op2 !== 64'd0) begin errors++; $display("FAIL xzr_ops got %h/%h exp 0/0", out_op1, out_op2); end
    d_exm_rd = 5'd7;
    set_instr(5'd7, 1'b0, 5'd7, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unused_no_stall got %0b exp 1", in_ready); end
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd10 || out_valid !== 1'b1) begin errors++; $display("FAIL unused_cnt got cnt=%0d v=%0b exp 10/1", stall_cnt, out_valid); end
    in_valid = 1'b0; d_exm_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    d_rd1 = 64'h11; d_rd2 = 64'h22;
    @(negedge clk);
    out_ready = 1'b0;
    set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b1);
    d_rd1 = 64'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b exp 0", i, in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_op1 !== 64'h11 || out_op2 !== 64'h22 || out_rd !== 5'd9 || out_memread !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%0b op1=%h op2=%h rd=%0d mr=%0b exp 1/11/22/9/0", i, out_valid, out_op1, out_op2, out_rd, out_memread);
      end
    end
    flush = 1'b1;
    set_instr(5'd9, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", out_valid); end
    checks++; if (out_rd !== 5'd9 || out_op1 !== 64'h11) begin errors++; $display("FAIL flush_keeps got rd=%0d op1=%h exp 9/11", out_rd, out_op1); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL flush_stall_cnt got %0d exp 0", stall_cnt); end
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    d_exm_valid = 1'b1; d_exm_regwrite = 1'b1; d_exm_memread = 1'b1; d_exm_rd = 5'd4;
    set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    set_instr(5'd4, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (stall_cnt !== 16'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset got cnt=%0d v=%0b exp 3/1", stall_cnt, out_valid); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_stall_reset got cnt=%0d v=%0b exp 0/0", stall_cnt, out_valid); end
    reset = 1'b0; out_ready = 1'b1; in_valid = 1'b0; d_exm_valid = 1'b0;
  endtask

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(7) == 0) return 5'd31;
    return 5'($urandom_range(3));
  endfunction

  task automatic test_random_stream();
    logic [63:0] arch [32];
    hist_t       h1, h2;
    logic [63:0] e1, e2;
    logic [4:0]  s;
    logic        u, hz, acc, rw;
    int          issued = 0;
    int          model_stalls = 0;
    do_reset();
    for (int i = 0; i < 32; i++) arch[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    pipe_auto = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    h1 = '0; h2 = '0;
    while (issued < NumInstr && errors < 50) begin
      if (!in_valid && $urandom_range(9) >= 2) begin
        rw = ($urandom_range(4) != 0);
        set_instr(rand_reg(), 1'($urandom_range(1)), rand_reg(), 1'($urandom_range(1)),
                  rand_reg(), rw, rw & ($urandom_range(2) == 0));
        cur_res = {$urandom, $urandom};
      end
      #1;
      hz = 1'b0;
      for (int k = 0; k < 2; k++) begin
        s = (k == 0) ? in_rn : in_rm;
        u = (k == 0) ? in_rn_used : in_rm_used;
        if (u && s != 5'd31) begin
          if (h1.v && h1.rw && h1.rd == s) hz = 1'b1;
          if (h2.v && h2.rw && h2.mr && h2.rd == s) hz = 1'b1;
        end
      end
      checks++; if (in_ready !== !(in_valid && hz)) begin
        errors++; $display("FAIL rand_in_ready instr %0d got %0b exp %0b", issued, in_ready, !(in_valid && hz));
      end
      if (in_valid && hz) model_stalls++;
      acc = in_valid && !hz;
      e1 = (in_rn == 5'd31) ? 64'd0 : arch[in_rn];
      e2 = (in_rm == 5'd31) ? 64'd0 : arch[in_rm];
      if (acc && in_regwrite && in_rd != 5'd31) arch[in_rd] = cur_res;
      h2 = h1;
      h1 = acc ? hist_t'{v: 1'b1, rw: in_regwrite, mr: in_memread, rd: in_rd} : '0;
      @(negedge clk);
      checks++; if (out_valid !== acc) begin errors++; $display("FAIL rand_out_valid instr %0d got %0b exp %0b", issued, out_valid, acc); end
      if (acc) begin
        checks++; if (in_rn_used && out_op1 !== e1) begin errors++; $display("FAIL rand_op1 instr %0d x%0d got %h exp %h", issued, in_rn, out_op1, e1); end
        checks++; if (in_rm_used && out_op2 !== e2) begin errors++; $display("FAIL rand_op2 instr %0d x%0d got %h exp %h", issued, in_rm, out_op2, e2); end
        checks++; if (out_rd !== in_rd || out_regwrite !== in_regwrite || out_memread !== in_memread) begin
          errors++; $display("FAIL rand_ctrl instr %0d got rd=%0d rw=%0b mr=%0b exp %0d/%0b/%0b", issued, out_rd, out_regwrite, out_memread, in_rd, in_regwrite, in_memread);
        end
        issued++;
        in_valid = 1'b0;
      end
    end
    checks++; if (stall_cnt !== 16'(model_stalls)) begin errors++; $display("FAIL rand_stall_cnt got %0d exp %0d", stall_cnt, model_stalls); end
    checks++; if (s_stall_cnt !== ((model_stalls > 7) ? 3'd7 : 3'(model_stalls))) begin
      errors++; $display("FAIL rand_sat_cnt got %0d exp min(%0d,7)", s_stall_cnt, model_stalls);
    end
    in_valid = 1'b0;
    pipe_auto = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wb_forward();
    test_ex_hazard();
    test_load_hazard();
    test_back_pressure();
    test_reset_mid_stall();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
